// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: default widths, forward-select
// encodings and the Tnew/Tuse values of each instruction class.
package hazard_scoreboard_pkg;

  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned TNEW_W     = 2;

  // D-stage forward selects
  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  // E-stage forward selects (0 keeps the D/E pipeline register value)
  localparam logic [1:0] FWD_EX_M = 2'd1;
  localparam logic [1:0] FWD_W    = 2'd2;

  // Tuse: cycles from D until the operand is consumed
  localparam logic [TNEW_W-1:0] TUSE_BRANCH = 2'd0;
  localparam logic [TNEW_W-1:0] TUSE_ALU    = 2'd1;
  localparam logic [TNEW_W-1:0] TUSE_STORE  = 2'd2;
  localparam logic [TNEW_W-1:0] TUSE_NONE   = 2'd3;

  // Tnew: cycles from E until the result exists
  localparam logic [TNEW_W-1:0] TNEW_LINK = 2'd0;
  localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

endpackage

// File: rtl/hazard_scoreboard_slot.sv
// hz_slot: one in-flight register write {valid, addr, tnew}.
// Ports:
//   clk, reset          clock and synchronous active-high clear
//   bubble              load an empty slot instead of the incoming write
//   in_valid/addr/tnew  incoming write (valid is further qualified by addr != 0)
//   src                 NumSrc source addresses to compare against
//   valid/addr/tnew     current slot contents
//   match               per source: slot live, same address, source not r0
module hz_slot #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned TW        = 2,
  parameter int unsigned NumSrc    = 2,
  parameter bit          Decrement = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           bubble,
  input  logic                           in_valid,
  input  logic [ADDR_W-1:0]              in_addr,
  input  logic [TW-1:0]                  in_tnew,
  input  logic [NumSrc-1:0][ADDR_W-1:0]  src,
  output logic                           valid,
  output logic [ADDR_W-1:0]              addr,
  output logic [TW-1:0]                  tnew,
  output logic [NumSrc-1:0]              match
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     tnew_q, tnew_d;

  always_comb begin
    valid_d = 1'b0;
    addr_d  = '0;
    tnew_d  = '0;
    if (!bubble) begin
      // r0 writes are architecturally discarded, so they never occupy a slot
      valid_d = in_valid && (in_addr != '0);
      addr_d  = in_addr;
      if (Decrement) begin
        tnew_d = (in_tnew == '0) ? '0 : in_tnew - 1'b1;
      end else begin
        tnew_d = in_tnew;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      tnew_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      tnew_q  <= tnew_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NumSrc); i++) begin
      match[i] = valid_q && (src[i] != '0) && (addr_q == src[i]);
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign tnew  = tnew_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight writes in E, M and W and derives the
// pipeline stall plus D- and E-stage forward selects of the 5-stage core.
// Ports:
//   clk, reset                    clock and synchronous active-high clear
//   d_rs, d_rt                    D-stage source addresses
//   d_tuse_rs, d_tuse_rt          Tuse per source (TUSE_NONE = unused)
//   d_wr_en, d_wr_addr, d_tnew    D instruction's destination write
//   d_md_use, md_busy             mult/div structural hazard
//   stall                         freeze PC and F/D, bubble into E
//   fwd_rs_d, fwd_rt_d            D select: GRF / E value / M value
//   fwd_rs_e, fwd_rt_e            E select: D/E reg / M value / W value
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W = GPR_ADDR_W,
  parameter int unsigned TW     = TNEW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_use,
  input  logic              md_busy,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e
);

  // Index 0 is rs, index 1 is rt throughout
  logic [1:0][ADDR_W-1:0] d_src, e_src;
  logic [1:0][TW-1:0]     d_tuse;
  logic [ADDR_W-1:0]      e_rs_q, e_rt_q;

  logic              e_valid, m_valid, w_valid;
  logic [ADDR_W-1:0] e_addr, m_addr, w_addr;
  logic [TW-1:0]     e_tnew, m_tnew, w_tnew;
  logic [1:0]        e_match_d, w_match_e;
  logic [3:0]        m_match;
  logic [1:0]        m_match_d, m_match_e;
  logic [1:0]        src_stall;
  logic [1:0][1:0]   fwd_d, fwd_e;

  assign d_src     = {d_rt, d_rs};
  assign e_src     = {e_rt_q, e_rs_q};
  assign d_tuse    = {d_tuse_rt, d_tuse_rs};
  assign m_match_d = m_match[1:0];
  assign m_match_e = m_match[3:2];

  hz_slot #(
    .ADDR_W    (ADDR_W),
    .TW        (TW),
    .NumSrc    (2),
    .Decrement (1'b0)
  ) u_slot_e (
    .clk      (clk),
    .reset    (reset),
    .bubble   (stall),
    .in_valid (d_wr_en),
    .in_addr  (d_wr_addr),
    .in_tnew  (d_tnew),
    .src      (d_src),
    .valid    (e_valid),
    .addr     (e_addr),
    .tnew     (e_tnew),
    .match    (e_match_d)
  );

  hz_slot #(
    .ADDR_W    (ADDR_W),
    .TW        (TW),
    .NumSrc    (4),
    .Decrement (1'b1)
  ) u_slot_m (
    .clk      (clk),
    .reset    (reset),
    .bubble   (1'b0),
    .in_valid (e_valid),
    .in_addr  (e_addr),
    .in_tnew  (e_tnew),
    .src      ({e_src, d_src}),
    .valid    (m_valid),
    .addr     (m_addr),
    .tnew     (m_tnew),
    .match    (m_match)
  );

  // Anything retiring in W has its value by definition, so its Tnew is zero
  hz_slot #(
    .ADDR_W    (ADDR_W),
    .TW        (TW),
    .NumSrc    (2),
    .Decrement (1'b0)
  ) u_slot_w (
    .clk      (clk),
    .reset    (reset),
    .bubble   (1'b0),
    .in_valid (m_valid),
    .in_addr  (m_addr),
    .in_tnew  ('0),
    .src      (e_src),
    .valid    (w_valid),
    .addr     (w_addr),
    .tnew     (w_tnew),
    .match    (w_match_e)
  );

  // W contents are only needed through its match output
  logic unused_w;
  assign unused_w = ^{w_valid, w_addr, w_tnew};

  always_comb begin
    src_stall = '0;
    fwd_d     = '0;
    fwd_e     = '0;
    for (int i = 0; i < 2; i++) begin
      src_stall[i] = (e_match_d[i] && (e_tnew > d_tuse[i])) ||
                     (m_match_d[i] && (m_tnew > d_tuse[i]));

      // Youngest live writer wins; a not-yet-ready E match must not fall back to M
      if (e_match_d[i]) begin
        fwd_d[i] = (e_tnew == '0) ? FWD_E : FWD_GRF;
      end else if (m_match_d[i] && (m_tnew == '0)) begin
        fwd_d[i] = FWD_M;
      end else begin
        fwd_d[i] = FWD_GRF;
      end

      if (m_match_e[i] && (m_tnew == '0)) begin
        fwd_e[i] = FWD_EX_M;
      end else if (w_match_e[i]) begin
        fwd_e[i] = FWD_W;
      end else begin
        fwd_e[i] = FWD_GRF;
      end
    end
  end

  assign stall    = (|src_stall) || (d_md_use && md_busy);
  assign fwd_rs_d = fwd_d[0];
  assign fwd_rt_d = fwd_d[1];
  assign fwd_rs_e = fwd_e[0];
  assign fwd_rt_e = fwd_e[1];

  // A stalled D instruction does not enter E, so E sees a bubble with r0 sources
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      e_rs_q <= '0;
      e_rt_q <= '0;
    end else begin
      e_rs_q <= d_rs;
      e_rt_q <= d_rt;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wr_addr;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_wr_en, d_md_use, md_busy;
  logic       stall;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_wr_en   (d_wr_en),
    .d_wr_addr (d_wr_addr),
    .d_tnew    (d_tnew),
    .d_md_use  (d_md_use),
    .md_busy   (md_busy),
    .stall     (stall),
    .fwd_rs_d  (fwd_rs_d),
    .fwd_rt_d  (fwd_rt_d),
    .fwd_rs_e  (fwd_rs_e),
    .fwd_rt_e  (fwd_rt_e)
  );

  typedef struct {
    bit         rst;
    logic [4:0] rs, rt;
    logic [1:0] tu_rs, tu_rt;
    bit         wr;
    logic [4:0] wa;
    logic [1:0] tn;
    bit         chk;
    logic       st;
    logic [1:0] frs_d, frt_d, frs_e, frt_e;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  function automatic vec_t v(bit rst, int rs, int rt, int tur, int tut, bit wr, int wa,
                             int tn, bit chk, bit st, int frd, int frtd, int fre, int frte);
    vec_t r;
    r.rst = rst; r.rs = 5'(rs); r.rt = 5'(rt); r.tu_rs = 2'(tur); r.tu_rt = 2'(tut);
    r.wr = wr; r.wa = 5'(wa); r.tn = 2'(tn); r.chk = chk; r.st = st;
    r.frs_d = 2'(frd); r.frt_d = 2'(frtd); r.frs_e = 2'(fre); r.frt_e = 2'(frte);
    return r;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input int rs, input int rt, input int tur, input int tut,
                       input bit wr, input int wa, input int tn, input bit mdu, input bit mdb);
    reset = rst; d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(tur); d_tuse_rt = 2'(tut);
    d_wr_en = wr; d_wr_addr = 5'(wa); d_tnew = 2'(tn); d_md_use = mdu; md_busy = mdb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // rst rs rt tur tut wr wa tn chk | stall frs_d frt_d frs_e frt_e
    vecs[0]  = v(1, 5, 7, 0, 0, 1, 9, 2, 0, 0, 0, 0, 0, 0);  // reset with garbage
    vecs[1]  = v(1, 9, 5, 0, 0, 1, 9, 2, 1, 0, 0, 0, 0, 0);
    vecs[2]  = v(0, 9, 5, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);  // nothing survived reset
    vecs[3]  = v(0, 0, 0, 3, 3, 1, 1, 2, 1, 0, 0, 0, 0, 0);  // lw $1
    vecs[4]  = v(0, 1, 2, 1, 1, 1, 3, 1, 1, 1, 0, 0, 0, 0);  // addu uses $1: stall
    vecs[5]  = v(0, 1, 2, 1, 1, 1, 3, 1, 1, 0, 0, 0, 0, 0);  // held, released
    vecs[6]  = v(0, 0, 0, 3, 3, 0, 0, 0, 1, 0, 0, 0, 2, 0);  // addu in E: rs from W
    vecs[7]  = v(0, 0, 0, 3, 3, 1, 2, 1, 1, 0, 0, 0, 0, 0);  // addu $2
    vecs[8]  = v(0, 2, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0);  // beq $2: stall
    vecs[9]  = v(0, 2, 0, 0, 3, 0, 0, 0, 1, 0, 2, 0, 0, 0);  // beq: rs from M
    vecs[10] = v(0, 0, 0, 3, 3, 1, 31, 0, 1, 0, 0, 0, 2, 0); // jal; beq in E sees W
    vecs[11] = v(0, 31, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0, 0, 0); // jr $31: rs from E
    vecs[12] = v(0, 0, 0, 3, 3, 1, 0, 2, 1, 0, 0, 0, 1, 0);  // write $0; jr in E from M
    vecs[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);  // reader of $0
    vecs[14] = v(0, 0, 0, 3, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[15] = v(0, 0, 0, 3, 3, 1, 4, 1, 1, 0, 0, 0, 0, 0);  // alu $4
    vecs[16] = v(0, 0, 4, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);  // rt reader: stall
    vecs[17] = v(0, 0, 4, 3, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0);  // rt from M
    vecs[18] = v(0, 0, 0, 3, 3, 1, 5, 1, 1, 0, 0, 0, 0, 2);  // rt in E from W
    vecs[19] = v(0, 0, 5, 3, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0);  // store data tuse 2: no stall
    vecs[20] = v(0, 0, 0, 3, 3, 0, 0, 0, 1, 0, 0, 0, 0, 1);  // store in E: rt from M
    vecs[21] = v(0, 0, 0, 3, 3, 1, 6, 0, 1, 0, 0, 0, 0, 0);  // link $6
    vecs[22] = v(0, 0, 0, 3, 3, 1, 6, 1, 1, 0, 0, 0, 0, 0);  // alu $6
    vecs[23] = v(0, 6, 0, 2, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0);  // unready E blocks ready M
    vecs[24] = v(0, 0, 0, 3, 3, 0, 0, 0, 1, 0, 0, 0, 1, 0);  // M beats W in E
    vecs[25] = v(0, 0, 0, 3, 3, 1, 7, 2, 1, 0, 0, 0, 0, 0);  // lw $7
    vecs[26] = v(0, 0, 0, 3, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[27] = v(0, 7, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0);  // stall from M slot
    vecs[28] = v(0, 7, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 0);  // W covered by GRF bypass

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, int'(vecs[i].rs), int'(vecs[i].rt), int'(vecs[i].tu_rs),
            int'(vecs[i].tu_rt), vecs[i].wr, int'(vecs[i].wa), int'(vecs[i].tn), 1'b0, 1'b0);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d stall", i), {1'b0, stall}, {1'b0, vecs[i].st});
        check($sformatf("v%0d fwd_rs_d", i), fwd_rs_d, vecs[i].frs_d);
        check($sformatf("v%0d fwd_rt_d", i), fwd_rt_d, vecs[i].frt_d);
        check($sformatf("v%0d fwd_rs_e", i), fwd_rs_e, vecs[i].frs_e);
        check($sformatf("v%0d fwd_rt_e", i), fwd_rt_e, vecs[i].frt_e);
      end
      tick();
    end

    // mult/div busy: stall holds while busy, drops in the same cycle busy does
    drive(0, 0, 0, 3, 3, 0, 0, 0, 0, 1);
    #1;
    check("md busy without md use", {1'b0, stall}, 2'd0);
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 3, 3, 1, 10, 1, 1, 1);
      #1;
      check($sformatf("md stall c%0d", c), {1'b0, stall}, 2'd1);
      tick();
    end
    drive(0, 0, 0, 3, 3, 1, 10, 1, 1, 0);
    #1;
    check("md release", {1'b0, stall}, 2'd0);
    tick();

    // Reset in the middle of a load-use stall discards the load
    drive(0, 0, 0, 3, 3, 1, 8, 2, 0, 0);
    tick();
    drive(0, 8, 0, 0, 3, 0, 0, 0, 0, 0);
    #1;
    check("load-use stall from E", {1'b0, stall}, 2'd1);
    tick();
    #1;
    check("load-use stall from M", {1'b0, stall}, 2'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("stall after mid-stall reset", {1'b0, stall}, 2'd0);
    check("fwd_rs_d after mid-stall reset", fwd_rs_d, 2'd0);
    check("fwd_rs_e after mid-stall reset", fwd_rs_e, 2'd0);
    tick();
    #1;
    check("no residual stall", {1'b0, stall}, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
